fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Sequences the radix-2 butterfly stages of one FFT frame and applies block-floating-point rescaling. It starts each stage on the butterfly engine, samples that stage's overflow flag on completion and decides whether the next stage's inputs are right-shifted by one. It also drives the control and overflow-statistics inputs of `scale_factor_tracker`. It sits between the host control/CSR logic and the butterfly datapath.

## Interface
- `MAX_LOG2N`, 12: largest supported log2(FFT length).
- `STAGE_W`, 8: width of stage index outputs; must be ≥ clog2(MAX_LOG2N).
- `TIMEOUT_CYCLES`, 4096: watchdog limit per stage; only used when `FFT_SEQ_TIMEOUT_EN` is defined.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  frame start request; honoured only in IDLE.
- `log2n_i`  in  4  stage count; sampled with `start_i`.
- `rescale_en_i`  in  1  enables overflow-driven rescaling; sampled with `start_i`.
- `abort_i`  in  1  abandon the current frame.
- `stage_done_i`  in  1  butterfly engine finished the current stage (1-cycle pulse).
- `stage_overflow_i`  in  1  engine overflow flag; valid with `stage_done_i`.
- `overflow_mag_i`  in  8  overflow magnitude; valid with `stage_done_i`.
- `stage_start_o`  out  1  start-stage pulse to the engine.
- `stage_idx_o`  out  STAGE_W  current stage index.
- `scale_shift_o`  out  1  engine must shift the current stage's inputs right by 1.
- `trk_fft_start_o`, `trk_track_en_o`, `trk_scale_inc_o`, `trk_stage_complete_o`  out  1  tracker controls.
- `trk_overflow_stage_o`, `trk_overflow_mag_o`  out  8  tracker overflow stage and magnitude.
- `busy_o`, `done_o`, `aborted_o`, `cfg_err_o`, `timeout_o`  out  1  status.

## Operation
States: IDLE, START, ISSUE, WAIT, POST, DONE.

- **IDLE**
  - `start_i` with 1 ≤ `log2n_i` ≤ MAX_LOG2N → START. Latch `log2n`, latch `rescale_en`, clear `stage_idx`, clear `pending_shift`.
  - `start_i` with an out-of-range `log2n_i` → `cfg_err_o` 1-cycle pulse; stay in IDLE.
- **START** (1 cycle): `trk_fft_start_o`=1 → ISSUE.
- **ISSUE** (1 cycle): `stage_start_o`=1 → WAIT.
- **WAIT**: on `stage_done_i`, latch `ovf = stage_overflow_i & rescale_en` and latch `overflow_mag_i` → POST.
- **POST** (1 cycle):
  - `trk_stage_complete_o`=1.
  - `trk_scale_inc_o`=`ovf`; `trk_overflow_stage_o`=`stage_idx` zero-extended; `trk_overflow_mag_o`=latched magnitude.
  - `pending_shift` ← `ovf`.
  - If `stage_idx` = log2n−1 → DONE; otherwise `stage_idx`+1 → ISSUE.
- **DONE** (1 cycle): `done_o`=1 → IDLE.

Output rules:
- `scale_shift_o` = `pending_shift`. It is stable from ISSUE through POST of each stage.
- Overflow in the final stage still pulses `trk_scale_inc_o` but produces no further shift.
- `trk_track_en_o` = latched `rescale_en`; it is held until the next accepted start.
- `busy_o`=1 in every state except IDLE.

Boundaries:
- `start_i` while busy: ignored.
- `stage_done_i` outside WAIT: ignored.
- `abort_i` in any non-IDLE state → IDLE next cycle with a 1-cycle `aborted_o`. It has priority over `stage_done_i` in the same cycle, and no tracker pulse is issued that cycle.
- `abort_i` in IDLE: no effect.
- `log2n_i`=1: exactly one stage.

## Timing
- Every output is a registered state decode or register; no input-to-output combinational path.
- `start_i` accepted at cycle 0 → cycle 1: `busy_o`=1 and `trk_fft_start_o`=1; cycle 2: `stage_start_o`.
- `stage_done_i` at cycle t → POST pulses at t+1 → next `stage_start_o` at t+2, or `done_o` at t+2.
- Minimum frame length, when each `stage_done_i` arrives in the first WAIT cycle: start → `done_o` = 3·log2n + 2 cycles.
- Reset value of every output: 0. Internal state is cleared and the FSM is in IDLE.
- Asserting reset mid-frame aborts silently, with no `aborted_o` pulse.

## Configuration
Macro: `FFT_SEQ_TIMEOUT_EN`.
- **Defined**
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES with no `stage_done_i` → IDLE with a 1-cycle `timeout_o` and no tracker pulses.
  - A `stage_done_i` in the same cycle as the timeout wins.
- **Undefined**: no counter; `timeout_o` is tied to 0 and WAIT waits indefinitely.

## Structure
- Shared package `fft_pkg` holds:
  - the state enum `fft_seq_state_e`;
  - `FFT_MAX_LOG2N`;
  - the tracker interface field widths (8-bit overflow stage and magnitude).
- Single module; no sub-module is needed. The watchdog counter is inline under the macro.

## Test plan
- **Clean frame**: `log2n_i`=3, `rescale_en_i`=1, no overflow, `stage_done_i` 4 cycles after each `stage_start_o` → 3 stage starts, 3 `trk_stage_complete_o`, 0 `trk_scale_inc_o`, `scale_shift_o`=0 throughout, `done_o` present.
- **Overflow and rescale**: `log2n_i`=4, overflow in stage 1 with magnitude 0x23 → one `trk_scale_inc_o` with stage=1 and mag=0x23; `scale_shift_o`=1 during stage 2 only.
- **Rescale disabled**: overflow on every stage with `rescale_en_i`=0 → no `trk_scale_inc_o`, `scale_shift_o`=0, `trk_track_en_o`=0.
- **Bad config**: `start_i` with `log2n_i`=0 and then with 13 → `cfg_err_o` pulse each time, `busy_o` stays 0. Also `start_i` while busy → ignored.
- **Abort**: `abort_i` together with `stage_done_i` in stage 2 → `aborted_o` next cycle, no `trk_stage_complete_o`, IDLE. Then a new `start_i` runs a full frame.
- **Timeout** (macro defined, TIMEOUT_CYCLES=16): no `stage_done_i` → `timeout_o` 16 cycles after entering WAIT, then IDLE. With the macro undefined: still busy after 1000 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT control definitions: sequencer state encoding, frame-size limit
// and the tracker interface field widths.
package fft_pkg;

    localparam int unsigned FFT_MAX_LOG2N = 12;
    localparam int unsigned FFT_LOG2N_W   = 4;
    localparam int unsigned TRK_STAGE_W   = 8;
    localparam int unsigned TRK_MAG_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } fft_seq_state_e;

endpackage

// File: rtl/fft_stage_sequencer.sv
// Radix-2 stage sequencer with block-floating-point rescale decisions.
// Optional per-stage watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned MAX_LOG2N      = FFT_MAX_LOG2N,
    parameter int unsigned STAGE_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [FFT_LOG2N_W-1:0] log2n_i,
    input  logic                   rescale_en_i,
    input  logic                   abort_i,
    input  logic                   stage_done_i,
    input  logic                   stage_overflow_i,
    input  logic [TRK_MAG_W-1:0]   overflow_mag_i,
    output logic                   stage_start_o,
    output logic [STAGE_W-1:0]     stage_idx_o,
    output logic                   scale_shift_o,
    output logic                   trk_fft_start_o,
    output logic                   trk_track_en_o,
    output logic                   trk_scale_inc_o,
    output logic                   trk_stage_complete_o,
    output logic [TRK_STAGE_W-1:0] trk_overflow_stage_o,
    output logic [TRK_MAG_W-1:0]   trk_overflow_mag_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic                   cfg_err_o,
    output logic                   timeout_o
);

    if (STAGE_W < $clog2(MAX_LOG2N) || MAX_LOG2N > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("fft_stage_sequencer: invalid parameterisation");
    end

    fft_seq_state_e         state_q, state_d;
    logic [FFT_LOG2N_W-1:0] log2n_q, log2n_d;
    logic                   rescale_en_q, rescale_en_d;
    logic [STAGE_W-1:0]     stage_idx_q, stage_idx_d;
    logic                   pending_shift_q, pending_shift_d;
    logic                   ovf_q, ovf_d;
    logic [TRK_MAG_W-1:0]   mag_q, mag_d;
    logic [TRK_STAGE_W-1:0] ovf_stage_q, ovf_stage_d;
    logic                   stage_start_q, stage_start_d;
    logic                   trk_fft_start_q, trk_fft_start_d;
    logic                   trk_scale_inc_q, trk_scale_inc_d;
    logic                   trk_stage_complete_q, trk_stage_complete_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   log2n_ok;
    logic                   last_stage;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;
`endif

    assign log2n_ok   = (log2n_i != '0) && (32'(log2n_i) <= MAX_LOG2N);
    assign last_stage = (stage_idx_q == STAGE_W'(log2n_q - FFT_LOG2N_W'(1)));

    // Next-state and registered-output decode
    always_comb begin
        state_d         = state_q;
        log2n_d         = log2n_q;
        rescale_en_d    = rescale_en_q;
        stage_idx_d     = stage_idx_q;
        pending_shift_d = pending_shift_q;
        ovf_d           = ovf_q;
        mag_d           = mag_q;
        ovf_stage_d     = ovf_stage_q;
        aborted_d       = 1'b0;
        cfg_err_d       = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
        wdog_d          = wdog_q;
        timeout_d       = 1'b0;
`endif

        if (state_q != ST_IDLE && abort_i) begin
            state_d         = ST_IDLE;
            aborted_d       = 1'b1;
            pending_shift_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (log2n_ok) begin
                            state_d         = ST_START;
                            log2n_d         = log2n_i;
                            rescale_en_d    = rescale_en_i;
                            stage_idx_d     = '0;
                            pending_shift_d = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_START: state_d = ST_ISSUE;
                ST_ISSUE: begin
                    state_d = ST_WAIT;
`ifdef FFT_SEQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
                ST_WAIT: begin
                    if (stage_done_i) begin
                        state_d     = ST_POST;
                        ovf_d       = stage_overflow_i & rescale_en_q;
                        mag_d       = overflow_mag_i;
                        ovf_stage_d = TRK_STAGE_W'(stage_idx_q);
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d         = ST_IDLE;
                        timeout_d       = 1'b1;
                        pending_shift_d = 1'b0;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
`endif
                end
                ST_POST: begin
                    // A final-stage overflow is reported but never shifts anything.
                    if (last_stage) begin
                        state_d         = ST_DONE;
                        pending_shift_d = 1'b0;
                    end else begin
                        state_d         = ST_ISSUE;
                        stage_idx_d     = stage_idx_q + STAGE_W'(1);
                        pending_shift_d = ovf_q;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d               = (state_d != ST_IDLE);
        trk_fft_start_d      = (state_d == ST_START);
        stage_start_d        = (state_d == ST_ISSUE);
        trk_stage_complete_d = (state_d == ST_POST);
        trk_scale_inc_d      = (state_d == ST_POST) && ovf_d;
        done_d               = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q              <= ST_IDLE;
            log2n_q              <= '0;
            rescale_en_q         <= 1'b0;
            stage_idx_q          <= '0;
            pending_shift_q      <= 1'b0;
            ovf_q                <= 1'b0;
            mag_q                <= '0;
            ovf_stage_q          <= '0;
            stage_start_q        <= 1'b0;
            trk_fft_start_q      <= 1'b0;
            trk_scale_inc_q      <= 1'b0;
            trk_stage_complete_q <= 1'b0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            aborted_q            <= 1'b0;
            cfg_err_q            <= 1'b0;
        end else begin
            state_q              <= state_d;
            log2n_q              <= log2n_d;
            rescale_en_q         <= rescale_en_d;
            stage_idx_q          <= stage_idx_d;
            pending_shift_q      <= pending_shift_d;
            ovf_q                <= ovf_d;
            mag_q                <= mag_d;
            ovf_stage_q          <= ovf_stage_d;
            stage_start_q        <= stage_start_d;
            trk_fft_start_q      <= trk_fft_start_d;
            trk_scale_inc_q      <= trk_scale_inc_d;
            trk_stage_complete_q <= trk_stage_complete_d;
            busy_q               <= busy_d;
            done_q               <= done_d;
            aborted_q            <= aborted_d;
            cfg_err_q            <= cfg_err_d;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    // Per-stage watchdog
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign stage_start_o        = stage_start_q;
    assign stage_idx_o          = stage_idx_q;
    assign scale_shift_o        = pending_shift_q;
    assign trk_fft_start_o      = trk_fft_start_q;
    assign trk_track_en_o       = rescale_en_q;
    assign trk_scale_inc_o      = trk_scale_inc_q;
    assign trk_stage_complete_o = trk_stage_complete_q;
    assign trk_overflow_stage_o = ovf_stage_q;
    assign trk_overflow_mag_o   = mag_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign aborted_o            = aborted_q;
    assign cfg_err_o            = cfg_err_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: engine responder plus a
// frame-level reference model of stage counts, shifts and tracker pulses.
module tb_fft_stage_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] log2n_i = '0;
    logic       rescale_en_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       stage_done_i = 1'b0;
    logic       stage_overflow_i = 1'b0;
    logic [7:0] overflow_mag_i = '0;
    logic       stage_start_o;
    logic [7:0] stage_idx_o;
    logic       scale_shift_o;
    logic       trk_fft_start_o, trk_track_en_o, trk_scale_inc_o, trk_stage_complete_o;
    logic [7:0] trk_overflow_stage_o, trk_overflow_mag_o;
    logic       busy_o, done_o, aborted_o, cfg_err_o, timeout_o;

    int total = 0;
    int bad = 0;
    int       dly [16];
    logic [7:0] mg [16];

    always #5 clk_i = ~clk_i;

    fft_stage_sequencer #(.MAX_LOG2N(12), .STAGE_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .log2n_i(log2n_i),
        .rescale_en_i(rescale_en_i), .abort_i(abort_i), .stage_done_i(stage_done_i),
        .stage_overflow_i(stage_overflow_i), .overflow_mag_i(overflow_mag_i),
        .stage_start_o(stage_start_o), .stage_idx_o(stage_idx_o), .scale_shift_o(scale_shift_o),
        .trk_fft_start_o(trk_fft_start_o), .trk_track_en_o(trk_track_en_o),
        .trk_scale_inc_o(trk_scale_inc_o), .trk_stage_complete_o(trk_stage_complete_o),
        .trk_overflow_stage_o(trk_overflow_stage_o), .trk_overflow_mag_o(trk_overflow_mag_o),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .cfg_err_o(cfg_err_o),
        .timeout_o(timeout_o)
    );

    task automatic randomize_stages(input int fixed_dly);
        for (int i = 0; i < 16; i++) begin
            dly[i] = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 5));
            mg[i]  = 8'($urandom);
        end
    endtask

    // Runs one frame against the engine responder; all expectations come from the frame rules.
    task automatic drive_frame(input int l2n, input bit ren, input logic [15:0] ovf,
                               input int abort_stg, input bit inject, input string tag);
        int  cyc, k, done_at, exp_len, n_st, n_cp, n_inc, exp_st, exp_cp, exp_inc;
        bit  waiting, fin, busy_bad, cfg_seen, ab_pend, shift_exp, fs_ok;
        cyc = 0; k = -1; done_at = 0; n_st = 0; n_cp = 0; n_inc = 0;
        waiting = 0; fin = 0; busy_bad = 0; cfg_seen = 0; ab_pend = 0; fs_ok = 1;
        exp_len = 2;
        for (int i = 0; i < l2n; i++) exp_len += dly[i] + 2;
        exp_st  = (abort_stg >= 0) ? abort_stg + 1 : l2n;
        exp_cp  = (abort_stg >= 0) ? abort_stg : l2n;
        exp_inc = 0;
        for (int i = 0; i < exp_cp; i++) if (ren && ovf[i]) exp_inc++;

        @(negedge clk_i);
        start_i = 1'b1; log2n_i = 4'(l2n); rescale_en_i = ren;
        while (!fin && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0; stage_done_i = 1'b0; stage_overflow_i = 1'b0;
            abort_i = 1'b0; overflow_mag_i = '0;
            if (cfg_err_o) cfg_seen = 1;
            if (trk_fft_start_o !== (cyc == 1)) fs_ok = 0;
            if (ab_pend) begin
                total++;
                if (aborted_o !== 1'b1 || busy_o !== 1'b0 || trk_stage_complete_o !== 1'b0 ||
                    trk_scale_inc_o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s abort_resp: aborted=%b busy=%b cmpl=%b inc=%b want 1 0 0 0",
                             tag, aborted_o, busy_o, trk_stage_complete_o, trk_scale_inc_o);
                end
                fin = 1;
            end else begin
                if (busy_o !== 1'b1) busy_bad = 1;
                if (stage_start_o === 1'b1) begin
                    k = n_st; n_st++;
                    shift_exp = (k > 0) && ren && ovf[k-1];
                    total++;
                    if (stage_idx_o !== 8'(k) || scale_shift_o !== shift_exp) begin
                        bad++;
                        $display("FAIL %s issue k=%0d: idx=%0d shift=%b want idx=%0d shift=%b",
                                 tag, k, stage_idx_o, scale_shift_o, k, shift_exp);
                    end
                    done_at = cyc + dly[k]; waiting = 1;
                end
                if (trk_stage_complete_o === 1'b1) begin
                    n_cp++;
                    if (trk_scale_inc_o === 1'b1) n_inc++;
                    total++;
                    if (trk_scale_inc_o !== (ren && ovf[k]) || trk_overflow_stage_o !== 8'(k) ||
                        trk_overflow_mag_o !== mg[k] || scale_shift_o !== shift_exp ||
                        trk_track_en_o !== ren) begin
                        bad++;
                        $display("FAIL %s post k=%0d: inc=%b stg=%0d mag=%h sh=%b ten=%b want %b %0d %h %b %b",
                                 tag, k, trk_scale_inc_o, trk_overflow_stage_o, trk_overflow_mag_o,
                                 scale_shift_o, trk_track_en_o, ren && ovf[k], k, mg[k], shift_exp, ren);
                    end
                end
                if (done_o === 1'b1) begin
                    total++;
                    if (cyc != exp_len || abort_stg >= 0 || scale_shift_o !== 1'b0) begin
                        bad++;
                        $display("FAIL %s done_time: cycle=%0d shift=%b want cycle=%0d shift=0 abort_stg=%0d",
                                 tag, cyc, scale_shift_o, exp_len, abort_stg);
                    end
                    fin = 1;
                end else if (waiting && cyc == done_at) begin
                    stage_done_i = 1'b1; stage_overflow_i = ovf[k]; overflow_mag_i = mg[k];
                    waiting = 0;
                    if (k == abort_stg) begin abort_i = 1'b1; ab_pend = 1; end
                end else if (inject && $urandom_range(0, 5) == 0) begin
                    start_i = 1'b1; log2n_i = 4'($urandom_range(0, 15));
                end
            end
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL %s frame_end: no done/aborted within %0d cycles", tag, cyc);
        end
        total++;
        if (n_st != exp_st || n_cp != exp_cp || n_inc != exp_inc) begin
            bad++;
            $display("FAIL %s counts: starts=%0d cmpl=%0d inc=%0d want %0d %0d %0d",
                     tag, n_st, n_cp, n_inc, exp_st, exp_cp, exp_inc);
        end
        total++;
        if (busy_bad || cfg_seen || !fs_ok) begin
            bad++;
            $display("FAIL %s status: busy_drop=%b cfg_err_seen=%b fft_start_ok=%b want 0 0 1",
                     tag, busy_bad, cfg_seen, fs_ok);
        end
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || aborted_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: busy=%b done=%b aborted=%b want 0 0 0",
                     tag, busy_o, done_o, aborted_o);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        total++;
        if ({stage_start_o, scale_shift_o, trk_fft_start_o, trk_track_en_o, trk_scale_inc_o,
             trk_stage_complete_o, busy_o, done_o, aborted_o, cfg_err_o, timeout_o} !== 11'b0 ||
            stage_idx_o !== 8'd0 || trk_overflow_stage_o !== 8'd0 || trk_overflow_mag_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b idx=%0d ostg=%0d omag=%h want all zero",
                     busy_o, stage_idx_o, trk_overflow_stage_o, trk_overflow_mag_o);
        end
    endtask

    task automatic test_clean_frame();
        randomize_stages(4);
        drive_frame(3, 1'b1, 16'h0000, -1, 1'b0, "clean");
    endtask

    task automatic test_overflow_rescale();
        randomize_stages(0);
        mg[1] = 8'h23;
        drive_frame(4, 1'b1, 16'h0002, -1, 1'b0, "ovf_rescale");
        randomize_stages(0);
        drive_frame(2, 1'b1, 16'h0003, -1, 1'b0, "ovf_last");
        randomize_stages(1);
        drive_frame(1, 1'b1, 16'h0001, -1, 1'b0, "one_stage");
    endtask

    task automatic test_rescale_disabled();
        randomize_stages(0);
        drive_frame(5, 1'b0, 16'hFFFF, -1, 1'b0, "rescale_off");
        total++;
        if (trk_track_en_o !== 1'b0) begin
            bad++;
            $display("FAIL rescale_off track_en: got %b want 0", trk_track_en_o);
        end
    endtask

    task automatic test_bad_config();
        logic [3:0] vals [4];
        vals[0] = 4'd0; vals[1] = 4'd13; vals[2] = 4'($urandom_range(13, 15)); vals[3] = 4'd15;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            start_i = 1'b1; log2n_i = vals[i];
            @(negedge clk_i);
            start_i = 1'b0;
            total++;
            if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg log2n=%0d: cfg_err=%b busy=%b want 1 0", vals[i], cfg_err_o, busy_o);
            end
            @(negedge clk_i);
            total++;
            if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL bad_cfg_pulse log2n=%0d: cfg_err=%b busy=%b want 0 0", vals[i], cfg_err_o, busy_o);
            end
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        total++;
        if (aborted_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_abort: aborted=%b busy=%b want 0 0", aborted_o, busy_o);
        end
        randomize_stages(0);
        drive_frame(4, 1'b1, 16'($urandom), -1, 1'b1, "start_while_busy");
    endtask

    task automatic test_abort();
        randomize_stages(0);
        drive_frame(4, 1'b1, 16'($urandom), 2, 1'b0, "abort");
        randomize_stages(0);
        drive_frame(4, 1'b1, 16'($urandom), -1, 1'b0, "after_abort");
    endtask

    task automatic test_timeout();
        int cyc, seen;
        bit pulses;
        cyc = 0; seen = -1; pulses = 0;
        @(negedge clk_i);
        start_i = 1'b1; log2n_i = 4'd3; rescale_en_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
        while (cyc < 1000 && seen < 0) begin
            @(negedge clk_i);
            cyc++;
            if (trk_stage_complete_o || trk_scale_inc_o || done_o) pulses = 1;
            if (timeout_o === 1'b1) seen = cyc;
        end
`ifdef FFT_SEQ_TIMEOUT_EN
        total++;
        if (seen != 19 || busy_o !== 1'b0 || pulses) begin
            bad++;
            $display("FAIL timeout: at=%0d busy=%b pulses=%b want at=19 busy=0 pulses=0", seen, busy_o, pulses);
        end
        @(negedge clk_i);
        total++;
        if (timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: got %b want 0", timeout_o);
        end
`else
        total++;
        if (seen != -1 || busy_o !== 1'b1 || pulses) begin
            bad++;
            $display("FAIL no_timeout: timeout_at=%0d busy=%b pulses=%b want none 1 0", seen, busy_o, pulses);
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        total++;
        if (aborted_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wait_abort: aborted=%b busy=%b want 1 0", aborted_o, busy_o);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        @(negedge clk_i);
        start_i = 1'b1; log2n_i = 4'd6; rescale_en_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || aborted_o !== 1'b0 || trk_track_en_o !== 1'b0 || stage_idx_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b aborted=%b ten=%b idx=%0d want 0 0 0 0",
                     busy_o, aborted_o, trk_track_en_o, stage_idx_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 10; f++) begin
            randomize_stages(0);
            drive_frame(int'($urandom_range(1, 12)), 1'($urandom), 16'($urandom), -1, 1'($urandom),
                        "random_frame");
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_overflow_rescale();
        test_rescale_disabled();
        test_bad_config();
        test_abort();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
